// File: rtl/conv_pkg.sv
// Shared LSU request types used by conv_lsu_arbiter and conv_unit.
//   lsu_req_id_t : which requester owns an in-flight read (core or conv_unit)
//   lsu_req_t    : one memory request as presented to the LSU port
package conv_pkg;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_CONV = 1'b1
  } lsu_req_id_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } lsu_req_t;

  localparam logic [3:0] FULL_MASK = 4'hF;

  // Build a read request; reads always enable every byte lane.
  function automatic lsu_req_t make_read(input logic [31:0] addr);
    lsu_req_t r;
    r.wr    = 1'b0;
    r.addr  = addr;
    r.wdata = '0;
    r.mask  = FULL_MASK;
    return r;
  endfunction

endpackage

// File: rtl/conv_tag_fifo.sv
// Synchronous FIFO of requester IDs, one entry per in-flight read.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : enqueue an ID (ignored when full)
//   pop, dout   : dequeue the head ID (ignored when empty); dout shows the head
//   count       : registered occupancy, full/empty derived from it
module conv_tag_fifo
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  lsu_req_id_t                din,
  input  logic                       pop,
  output lsu_req_id_t                dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  lsu_req_id_t   store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = store[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_lsu_arbiter.sv
// Shares the single data-memory LSU port between the core load/store pipeline
// (requester 0) and the conv_unit operand fetcher (requester 1).
// Fixed priority to the core; conv_unit is promoted after waiting STARVE_LIMIT
// consecutive cycles. Read responses come back in order and are routed to the
// owning requester via an internal requester-ID FIFO.
//   clk, rst              : clock, synchronous active-high reset
//   core_*                : core request (read or write) and read-data return
//   conv_*                : conv_unit read request and read-data return
//   mem_*                 : memory-side request and in-order read response
//   outstanding_o         : number of reads in flight
//   err_o                 : sticky, a response arrived with nothing outstanding
module conv_lsu_arbiter
  import conv_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               core_req_i,
  input  logic                               core_wr_i,
  input  logic [31:0]                        core_addr_i,
  input  logic [31:0]                        core_wdata_i,
  input  logic [3:0]                         core_mask_i,
  output logic                               core_req_ready_o,
  output logic                               core_data_valid_o,
  output logic [31:0]                        core_data_o,
  input  logic                               conv_req_i,
  input  logic [31:0]                        conv_addr_i,
  output logic                               conv_req_ready_o,
  output logic                               conv_data_valid_o,
  output logic [31:0]                        conv_data_o,
  output logic                               mem_req_o,
  output logic                               mem_wr_o,
  output logic [31:0]                        mem_addr_o,
  output logic [31:0]                        mem_wdata_o,
  output logic [3:0]                         mem_mask_o,
  input  logic                               mem_req_ready_i,
  input  logic                               mem_data_valid_i,
  input  logic [31:0]                        mem_data_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

  logic          fifo_full;
  logic          fifo_empty;
  lsu_req_id_t   head_id;
  lsu_req_id_t   push_id;

  logic          core_ok;
  logic          conv_ok;
  logic          promote;
  logic          grant_conv;
  logic          accept;
  logic          push;
  logic          pop;
  logic          stray;

  logic [WW-1:0] wait_cnt;

  lsu_req_t      core_req;
  lsu_req_t      conv_req;
  lsu_req_t      sel_req;

  // Eligibility: writes never occupy a tag slot, so only reads stall on full.
  // Everything is gated by rst so no request/ready/valid escapes during reset.
  assign core_ok    = ~rst & core_req_i & (core_wr_i | ~fifo_full);
  assign conv_ok    = ~rst & conv_req_i & ~fifo_full;
  assign promote    = (wait_cnt >= WW'(STARVE_LIMIT));
  assign grant_conv = conv_ok & (promote | ~core_ok);

  assign mem_req_o  = core_ok | conv_ok;
  assign accept     = mem_req_o & mem_req_ready_i;

  assign core_req_ready_o = accept & ~grant_conv;
  assign conv_req_ready_o = accept & grant_conv;

  always_comb begin
    core_req       = '0;
    core_req.wr    = core_wr_i;
    core_req.addr  = core_addr_i;
    core_req.wdata = core_wr_i ? core_wdata_i : '0;
    core_req.mask  = core_wr_i ? core_mask_i : FULL_MASK;
    conv_req       = make_read(conv_addr_i);
    sel_req        = grant_conv ? conv_req : core_req;
  end

  assign mem_wr_o    = sel_req.wr;
  assign mem_addr_o  = sel_req.addr;
  assign mem_wdata_o = sel_req.wdata;
  assign mem_mask_o  = sel_req.mask;

  // Only accepted reads get a tag; writes never produce a response.
  assign push    = accept & (grant_conv | ~core_wr_i);
  assign push_id = grant_conv ? REQ_CONV : REQ_CORE;

  // A response with no tag outstanding is dropped and flagged.
  assign pop   = ~rst & mem_data_valid_i & ~fifo_empty;
  assign stray = ~rst & mem_data_valid_i & fifo_empty;

  conv_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_id),
    .pop   (pop),
    .dout  (head_id),
    .count (outstanding_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign core_data_valid_o = pop & (head_id == REQ_CORE);
  assign conv_data_valid_o = pop & (head_id == REQ_CONV);
  assign core_data_o       = mem_data_i;
  assign conv_data_o       = mem_data_i;

  // Counts consecutive cycles conv_unit is kept waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (~conv_req_i | conv_req_ready_o) begin
      wait_cnt <= '0;
    end else if (~promote) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (stray) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_lsu_arbiter.sv
module tb_conv_lsu_arbiter;

  localparam int unsigned MAXO   = 4;
  localparam int unsigned STARVE = 8;

  logic        clk;
  logic        rst;
  logic        core_req_i, core_wr_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic [3:0]  core_mask_i;
  logic        core_req_ready_o, core_data_valid_o;
  logic [31:0] core_data_o;
  logic        conv_req_i;
  logic [31:0] conv_addr_i;
  logic        conv_req_ready_o, conv_data_valid_o;
  logic [31:0] conv_data_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_mask_o;
  logic        mem_req_ready_i, mem_data_valid_i;
  logic [31:0] mem_data_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  conv_lsu_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .STARVE_LIMIT    (STARVE)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .core_req_i        (core_req_i),
    .core_wr_i         (core_wr_i),
    .core_addr_i       (core_addr_i),
    .core_wdata_i      (core_wdata_i),
    .core_mask_i       (core_mask_i),
    .core_req_ready_o  (core_req_ready_o),
    .core_data_valid_o (core_data_valid_o),
    .core_data_o       (core_data_o),
    .conv_req_i        (conv_req_i),
    .conv_addr_i       (conv_addr_i),
    .conv_req_ready_o  (conv_req_ready_o),
    .conv_data_valid_o (conv_data_valid_o),
    .conv_data_o       (conv_data_o),
    .mem_req_o         (mem_req_o),
    .mem_wr_o          (mem_wr_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_mask_o        (mem_mask_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_data_valid_i  (mem_data_valid_i),
    .mem_data_i        (mem_data_i),
    .outstanding_o     (outstanding_o),
    .err_o             (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];       // expected responses, in order
  logic [31:0] pending[$];  // memory model: read data awaiting return

  int          n_cmp = 0;
  int          n_bad = 0;

  // reference model state
  int          m_cnt  = 0;
  int          m_wait = 0;
  logic        m_err  = 1'b0;

  // memory model controls
  logic        rdy     = 1'b1;
  logic        resp_en = 1'b1;

  // observations from the most recent step
  logic        acc_core, acc_conv;
  int          core_vcnt = 0, conv_vcnt = 0, push_cnt = 0;
  int          peak = 0;
  logic [31:0] last_core_data, last_conv_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory side, check every output against the
  // model and scoreboard, then advance model state across the clock edge.
  task automatic step();
    logic full, cok, vok, gconv, ereq, eacc, epush, epop, stray;
    exp_t e;
    if (resp_en && pending.size() > 0) begin
      mem_data_valid_i = 1'b1;
      mem_data_i       = pending[0];
    end else begin
      mem_data_valid_i = 1'b0;
      mem_data_i       = $urandom;
    end
    mem_req_ready_i = rdy;
    #3;
    full  = (m_cnt == MAXO);
    cok   = !rst && core_req_i && (core_wr_i || !full);
    vok   = !rst && conv_req_i && !full;
    gconv = vok && ((m_wait >= STARVE) || !cok);
    ereq  = cok || vok;
    eacc  = ereq && rdy;
    chk("mem_req", mem_req_o, ereq);
    chk("core_ready", core_req_ready_o, eacc && !gconv);
    chk("conv_ready", conv_req_ready_o, eacc && gconv);
    if (ereq) begin
      chk("mem_addr", mem_addr_o, gconv ? conv_addr_i : core_addr_i);
      chk("mem_wr", mem_wr_o, !gconv && core_wr_i);
      if (!gconv && core_wr_i) begin
        chk("mem_wdata", mem_wdata_o, core_wdata_i);
        chk("mem_mask_wr", mem_mask_o, core_mask_i);
      end else begin
        chk("mem_mask_rd", mem_mask_o, 4'hF);
      end
    end
    epop  = mem_data_valid_i && !rst && sb.size() > 0;
    stray = mem_data_valid_i && !rst && sb.size() == 0;
    e = '0;
    if (epop) e = sb.pop_front();
    chk("core_valid", core_data_valid_o, epop && !e.id);
    chk("conv_valid", conv_data_valid_o, epop && e.id);
    if (epop && !e.id) chk("core_data", core_data_o, e.data);
    if (epop && e.id)  chk("conv_data", conv_data_o, e.data);
    chk("outstanding", outstanding_o, m_cnt);
    chk("err", err_o, m_err);
    if (core_data_valid_o) begin core_vcnt++; last_core_data = core_data_o; end
    if (conv_data_valid_o) begin conv_vcnt++; last_conv_data = conv_data_o; end

    epush = eacc && (gconv || !core_wr_i);
    if (epush) begin
      sb.push_back({gconv, (gconv ? conv_addr_i : core_addr_i) >> 2});
      push_cnt++;
    end
    if (mem_data_valid_i) void'(pending.pop_front());
    if (mem_req_o && mem_req_ready_i && !mem_wr_o) pending.push_back(mem_addr_o >> 2);

    if (rst) begin
      m_cnt = 0; m_wait = 0; m_err = 1'b0; sb.delete();
    end else begin
      m_cnt = m_cnt + (epush ? 1 : 0) - (epop ? 1 : 0);
      if (!conv_req_i || (eacc && gconv)) m_wait = 0;
      else if (m_wait < STARVE) m_wait++;
      if (stray) m_err = 1'b1;
    end
    if (m_cnt > peak) peak = m_cnt;
    acc_core = eacc && !gconv;
    acc_conv = eacc && gconv;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int bud;
    core_req_i = 1'b0; conv_req_i = 1'b0; rdy = 1'b1; resp_en = 1'b1;
    bud = 0;
    while ((sb.size() > 0 || pending.size() > 0) && bud < 200) begin
      step(); bud++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int n, base_core, base_conv, base_push, issued;
    rst = 1'b1;
    core_req_i = 1'b0; core_wr_i = 1'b0; core_addr_i = '0; core_wdata_i = '0; core_mask_i = '0;
    conv_req_i = 1'b0; conv_addr_i = '0;
    mem_req_ready_i = 1'b0; mem_data_valid_i = 1'b0; mem_data_i = '0;
    @(posedge clk); #1;
    // reset state, with requests asserted to show they are masked
    core_req_i = 1'b1; conv_req_i = 1'b1;
    step();
    core_req_i = 1'b0; conv_req_i = 1'b0;
    rst = 1'b0;
    step();

    // 1: conv alone, 8 back-to-back reads
    base_core = core_vcnt; base_conv = conv_vcnt;
    conv_req_i = 1'b1; conv_addr_i = 32'h144; issued = 0; n = 0;
    while (issued < 8 && n < 50) begin
      step(); n++;
      if (acc_conv) begin issued++; conv_addr_i += 4; end
    end
    chk("t1_issued", issued, 8);
    drain();
    chk("t1_conv_valids", conv_vcnt - base_conv, 8);
    chk("t1_core_valids", core_vcnt - base_core, 0);
    chk("t1_last_data", last_conv_data, 32'h58);

    // 2: simultaneous core and conv reads, core wins first
    core_req_i = 1'b1; core_wr_i = 1'b0; core_addr_i = 32'h10;
    conv_req_i = 1'b1; conv_addr_i = 32'h20;
    step();
    chk("t2_core_first", acc_core, 1'b1);
    chk("t2_conv_waits", acc_conv, 1'b0);
    core_req_i = 1'b0;
    step();
    chk("t2_conv_second", acc_conv, 1'b1);
    conv_req_i = 1'b0;
    drain();
    chk("t2_core_data", last_core_data, 32'h4);
    chk("t2_conv_data", last_conv_data, 32'h8);

    // 3: core writes every cycle, conv promoted after STARVE_LIMIT waits
    core_req_i = 1'b1; core_wr_i = 1'b1; core_addr_i = 32'h300;
    core_wdata_i = 32'hA5A5_0000; core_mask_i = 4'h3;
    conv_req_i = 1'b1; conv_addr_i = 32'h40;
    n = 0;
    while (n < 20) begin
      step(); n++;
      if (acc_conv) break;
      core_addr_i += 4; core_wdata_i += 1;
    end
    chk("t3_promote_cycle", n, STARVE + 1);
    conv_addr_i = 32'h44;
    step();
    chk("t3_wait_cleared_core", acc_core, 1'b1);
    chk("t3_wait_cleared_conv", acc_conv, 1'b0);
    drain();

    // 4: fill the tag FIFO, then write passes while conv read stalls
    resp_en = 1'b0; rdy = 1'b1;
    conv_req_i = 1'b1; conv_addr_i = 32'h100; issued = 0; n = 0;
    while (issued < 4 && n < 20) begin
      step(); n++;
      if (acc_conv) begin issued++; conv_addr_i += 4; end
    end
    chk("t4_full_count", outstanding_o, 4);
    rdy = 1'b0;
    core_req_i = 1'b1; core_wr_i = 1'b1; core_addr_i = 32'h204;
    core_wdata_i = 32'h1234_5678; core_mask_i = 4'hC;
    step();
    chk("t4_not_ready_core", acc_core, 1'b0);
    rdy = 1'b1;
    step();
    chk("t4_write_passes", acc_core, 1'b1);
    chk("t4_conv_stalled", acc_conv, 1'b0);
    core_req_i = 1'b0;
    step();
    chk("t4_conv_still_stalled", acc_conv, 1'b0);
    resp_en = 1'b1;
    step();
    chk("t4_no_pop_bypass", acc_conv, 1'b0);
    step();
    chk("t4_conv_after_pop", acc_conv, 1'b1);
    conv_req_i = 1'b0;
    drain();
    chk("t4_peak", peak, 4);

    // 5: reset with reads in flight, later responses are strays
    resp_en = 1'b0;
    conv_req_i = 1'b1; conv_addr_i = 32'h80; issued = 0; n = 0;
    while (issued < 3 && n < 20) begin
      step(); n++;
      if (acc_conv) begin issued++; conv_addr_i += 4; end
    end
    conv_req_i = 1'b0;
    base_core = core_vcnt; base_conv = conv_vcnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t5_outstanding_cleared", outstanding_o, 0);
    resp_en = 1'b1;
    repeat (3) step();
    chk("t5_err_set", err_o, 1'b1);
    chk("t5_no_valid", (core_vcnt - base_core) + (conv_vcnt - base_conv), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t5_err_cleared", err_o, 1'b0);

    // 6: random mix
    base_core = core_vcnt; base_conv = conv_vcnt; base_push = push_cnt;
    acc_core = 1'b0; acc_conv = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!core_req_i || acc_core) begin
        core_req_i   = ($urandom_range(0, 1) == 1);
        core_wr_i    = ($urandom_range(0, 2) == 0);
        core_addr_i  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        core_wdata_i = $urandom;
        core_mask_i  = 4'($urandom_range(1, 15));
      end
      if (!conv_req_i || acc_conv) begin
        conv_req_i  = ($urandom_range(0, 1) == 1);
        conv_addr_i = {22'd1, 8'($urandom_range(0, 255)), 2'b00};
      end
      rdy     = ($urandom_range(0, 3) != 0);
      resp_en = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();
    chk("t6_all_answered", (core_vcnt - base_core) + (conv_vcnt - base_conv), push_cnt - base_push);
    chk("t6_err_clear", err_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
